// File: rtl/model_sqrt_arbiter_pkg.sv
// Shared definitions for the sqrt arbiter: FSM state encoding and
// single-bit control constants used by the arbiter and the sqrt unit.
package model_sqrt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

endpackage

// File: rtl/model_sqrt_arbiter_sqrt.sv
// Iterative unsigned integer square root, one result bit per clock.
// START loads the operand (and aborts any computation in flight);
// READY pulses for one cycle when DATA_OUT holds floor(sqrt(operand)).
// For an N-bit operand READY appears (N+1)/2 + 1 cycles after START.
module model_scalar_sqrt_function
  import model_sqrt_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int HALF = (DATA_SIZE + 1) / 2;
  localparam int XW   = 2 * HALF;
  localparam int RW   = HALF + 3;

  logic [XW-1:0]           r_x;
  logic [RW-1:0]           r_rem;
  logic [HALF-1:0]         r_root;
  logic [CONTROL_SIZE-1:0] r_cnt;
  logic                    r_busy;
  logic                    r_ready;

  logic [RW-1:0]   w_rem_sh;
  logic [RW-1:0]   w_trial;
  logic            w_ge;
  logic [RW-1:0]   w_rem_next;
  logic [HALF-1:0] w_root_next;

  // One restoring step: bring down the next two operand bits and try root*4+1.
  always_comb begin
    w_rem_sh    = (r_rem << 2) | RW'(r_x[XW-1 -: 2]);
    w_trial     = {1'b0, r_root, 2'b01};
    w_ge        = (w_rem_sh >= w_trial);
    w_rem_next  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    w_root_next = (r_root << 1) | HALF'(w_ge);
  end

  // Load on START, then iterate HALF times and pulse READY after the last step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x     <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_busy  <= ZERO;
      r_ready <= ZERO;
    end else begin
      r_ready <= ZERO;
      if (START) begin
        r_x    <= XW'(DATA_IN);
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= CONTROL_SIZE'(HALF);
        r_busy <= ONE;
      end else if (r_busy) begin
        r_x    <= r_x << 2;
        r_rem  <= w_rem_next;
        r_root <= w_root_next;
        r_cnt  <= r_cnt - CONTROL_SIZE'(1);
        if (r_cnt == CONTROL_SIZE'(1)) begin
          r_busy  <= ZERO;
          r_ready <= ONE;
        end
      end
    end
  end

  assign READY    = r_ready;
  assign DATA_OUT = DATA_SIZE'(r_root);

endmodule

// File: rtl/model_sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative sqrt unit among REQUESTERS
// clients, with a watchdog that forces a zero result and an ERROR pulse
// when the sqrt unit does not answer within TIMEOUT cycles of START.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | no operation; arbitrate and latch winner operand
//   ST_LAUNCH  | START pulse to the sqrt unit, watchdog reads zero
//   ST_WAIT    | watchdog counting, waiting for READY or expiry
//   ST_RESPOND | DONE/DATA_OUT/ERROR to the winner, update last grant
module model_sqrt_arbiter
  import model_sqrt_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int REQUESTERS   = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [REQUESTERS-1:0]           REQ,
  input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_IN,
  output logic [REQUESTERS-1:0]           GRANT,
  output logic [REQUESTERS-1:0]           DONE,
  output logic                            ERROR,
  output logic [DATA_SIZE-1:0]            DATA_OUT,
  output logic                            BUSY
);

  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_winner;
  logic [IDX_W-1:0]        r_last;
  logic [DATA_SIZE-1:0]    r_operand;
  logic [DATA_SIZE-1:0]    r_result;
  logic                    r_err;
  logic [CONTROL_SIZE-1:0] r_wd;

  logic [IDX_W-1:0]      w_pick;
  logic [DATA_SIZE-1:0]  w_pick_data;
  logic [REQUESTERS-1:0] w_winner_1h;
  logic                  w_any_req;
  logic                  w_expired;
  logic                  w_start;
  logic                  w_ready;
  logic [DATA_SIZE-1:0]  w_sqrt_out;

  // First requester strictly after 'last', wrapping; returns 'last' if none.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [REQUESTERS-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      cand = int'(last) + k;
      if (cand >= REQUESTERS) cand = cand - REQUESTERS;
      if (!found && req[cand[IDX_W-1:0]]) begin
        pick  = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_any_req   = |REQ;
  assign w_pick      = rr_pick(REQ, r_last);
  assign w_winner_1h = REQUESTERS'(1) << r_winner;
  // Watchdog equals the number of cycles since the START cycle.
  assign w_expired   = (r_wd == CONTROL_SIZE'(TIMEOUT - 1));

  // Select the operand slice belonging to the arbitration winner.
  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_pick == IDX_W'(i)) w_pick_data = DATA_IN[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode; outputs fall to zero with the state on reset.
  always_comb begin
    w_next   = r_state;
    w_start  = ZERO;
    GRANT    = '0;
    DONE     = '0;
    ERROR    = ZERO;
    DATA_OUT = '0;
    BUSY     = ONE;
    case (r_state)
      ST_IDLE: begin
        BUSY = ZERO;
        if (w_any_req) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_start = ONE;
        GRANT   = w_winner_1h;
        w_next  = ST_WAIT;
      end
      ST_WAIT: begin
        GRANT = w_winner_1h;
        if (w_ready || w_expired) w_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        GRANT    = w_winner_1h;
        DONE     = w_winner_1h;
        ERROR    = r_err;
        DATA_OUT = r_result;
        w_next   = ST_IDLE;
      end
      default: begin
        BUSY   = ZERO;
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch winner/operand, run watchdog, capture result or timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_winner  <= '0;
      r_last    <= IDX_W'(REQUESTERS - 1);
      r_operand <= '0;
      r_result  <= '0;
      r_err     <= ZERO;
      r_wd      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wd <= '0;
          if (w_any_req) begin
            r_winner  <= w_pick;
            r_operand <= w_pick_data;
            r_result  <= '0;
            r_err     <= ZERO;
          end
        end
        ST_LAUNCH: begin
          r_wd <= r_wd + CONTROL_SIZE'(1);
        end
        ST_WAIT: begin
          r_wd <= r_wd + CONTROL_SIZE'(1);
          // READY takes precedence over a simultaneous expiry.
          if (w_ready) begin
            r_result <= w_sqrt_out;
          end else if (w_expired) begin
            r_result <= '0;
            r_err    <= ONE;
          end
        end
        ST_RESPOND: begin
          r_last <= r_winner;
        end
        default: ;
      endcase
    end
  end

  model_scalar_sqrt_function #(
    .DATA_SIZE   (DATA_SIZE),
    .CONTROL_SIZE(CONTROL_SIZE)
  ) u_sqrt (
    .CLK     (CLK),
    .RST     (RST),
    .START   (w_start),
    .DATA_IN (r_operand),
    .READY   (w_ready),
    .DATA_OUT(w_sqrt_out)
  );

endmodule

// File: tb/tb_model_sqrt_arbiter.sv
// Bench for model_sqrt_arbiter: three instances (default timeout, short
// timeout, timeout coinciding with READY) driven from task-per-scenario
// stimulus and checked against an arithmetic reference model.
module tb_model_sqrt_arbiter;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [255:0] data_in = '0;
  logic [3:0]   req_m = '0, req_t = '0, req_e = '0;

  logic [3:0]  grant_m, done_m, grant_t, done_t, grant_e, done_e;
  logic        err_m, err_t, err_e, busy_m, busy_t, busy_e;
  logic [63:0] dout_m, dout_t, dout_e;

  int checks = 0;
  int errors = 0;
  longint unsigned ops [4];
  int last_m = 3;

  always #5 CLK = ~CLK;

  model_sqrt_arbiter u_m (
    .CLK(CLK), .RST(RST), .REQ(req_m), .DATA_IN(data_in), .GRANT(grant_m),
    .DONE(done_m), .ERROR(err_m), .DATA_OUT(dout_m), .BUSY(busy_m));

  model_sqrt_arbiter #(.TIMEOUT(8)) u_t (
    .CLK(CLK), .RST(RST), .REQ(req_t), .DATA_IN(data_in), .GRANT(grant_t),
    .DONE(done_t), .ERROR(err_t), .DATA_OUT(dout_t), .BUSY(busy_t));

  model_sqrt_arbiter #(.TIMEOUT(34)) u_e (
    .CLK(CLK), .RST(RST), .REQ(req_e), .DATA_IN(data_in), .GRANT(grant_e),
    .DONE(done_e), .ERROR(err_e), .DATA_OUT(dout_e), .BUSY(busy_e));

  // floor(sqrt(x)) by binary search on the 32-bit root range
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // round-robin expectation: first requesting index after 'last'
  function automatic int rr_next(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic longint unsigned rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic set_op(input int i, input longint unsigned v);
    data_in[i*64 +: 64] = v;
    ops[i] = v;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    req_m = '0; req_t = '0; req_e = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    last_m = 3;
  endtask

  // steps negedges until the chosen instance shows DONE or the limit expires
  task automatic wait_done(input int which, input int limit, output int n);
    logic [3:0] d;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      d = (which == 0) ? done_m : (which == 1) ? done_t : done_e;
    end while (d == 4'b0 && n < limit);
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b1;
    #1;
    checks++;
    if ({grant_m, done_m, err_m, busy_m} !== 10'b0 || dout_m !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs_m: grant=%b done=%b err=%b busy=%b dout=%0d, want all 0",
               grant_m, done_m, err_m, busy_m, dout_m);
    end
    checks++;
    if ({busy_t, busy_e, done_t, done_e} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs_te: busy_t=%b busy_e=%b done_t=%b done_e=%b, want 0",
               busy_t, busy_e, done_t, done_e);
    end
    @(negedge CLK);
    RST = 1'b0;
    last_m = 3;
  endtask

  task automatic test_single();
    int n;
    set_op(0, 64'd16);
    req_m = 4'b0001;
    @(negedge CLK);
    checks++;
    if (grant_m !== 4'b0001 || busy_m !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b, want 0001/1", grant_m, busy_m);
    end
    wait_done(0, 60, n);
    checks++;
    if (n !== 34 || done_m !== 4'b0001) begin
      errors++;
      $display("FAIL single_latency: cycles=%0d done=%b, want 34/0001", n, done_m);
    end
    checks++;
    if (dout_m !== 64'd4 || err_m !== 1'b0) begin
      errors++;
      $display("FAIL single_result: dout=%0d err=%b, want 4/0", dout_m, err_m);
    end
    req_m = 4'b0000;
    last_m = 0;
    @(negedge CLK);
    checks++;
    if (done_m !== 4'b0 || busy_m !== 1'b0 || dout_m !== 64'd0 || grant_m !== 4'b0) begin
      errors++;
      $display("FAIL single_pulse: done=%b busy=%b dout=%0d grant=%b, want 0", done_m, busy_m,
               dout_m, grant_m);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int n, exp;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, rand64());
    @(negedge CLK);
    req_m = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = rr_next(req_m, last_m);
      wait_done(0, 60, n);
      checks++;
      if (exp !== order[k] || done_m !== (4'b1 << order[k]) || !$onehot(done_m) ||
          n !== ((k == 0) ? 35 : 36)) begin
        errors++;
        $display("FAIL rr_order[%0d]: done=%b cycles=%0d, want %b/%0d", k, done_m, n,
                 4'b1 << order[k], (k == 0) ? 35 : 36);
      end
      checks++;
      if (dout_m !== isqrt(ops[order[k]])) begin
        errors++;
        $display("FAIL rr_data[%0d]: dout=%0d want %0d", k, dout_m, isqrt(ops[order[k]]));
      end
      last_m = order[k];
    end
    req_m = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_withdraw();
    int n, n2;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, rand64());
    @(negedge CLK);
    req_m = 4'b1101;
    wait_done(0, 60, n);
    checks++;
    if (done_m !== 4'b0001 || n !== 35) begin
      errors++;
      $display("FAIL wd_first: done=%b cycles=%0d, want 0001/35", done_m, n);
    end
    repeat (12) @(negedge CLK);
    checks++;
    if (grant_m !== 4'b0100 || busy_m !== 1'b1) begin
      errors++;
      $display("FAIL wd_grant2: grant=%b busy=%b, want 0100/1", grant_m, busy_m);
    end
    req_m[2] = 1'b0;
    wait_done(0, 60, n2);
    checks++;
    if (done_m !== 4'b0100 || n2 !== 24 || dout_m !== isqrt(ops[2]) || err_m !== 1'b0) begin
      errors++;
      $display("FAIL wd_done2: done=%b cycles=%0d dout=%0d err=%b, want 0100/24/%0d/0",
               done_m, n2, dout_m, err_m, isqrt(ops[2]));
    end
    last_m = 2;
    wait_done(0, 60, n);
    checks++;
    if (done_m !== (4'b1 << rr_next(req_m, last_m)) || done_m !== 4'b1000 || n !== 36) begin
      errors++;
      $display("FAIL wd_next: done=%b cycles=%0d, want 1000/36", done_m, n);
    end
    last_m = 3;
    req_m = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_data_change();
    int n;
    longint unsigned x, y;
    x = 64'd10000;
    y = 64'd1 << 40;
    set_op(1, x);
    req_m = 4'b0010;
    repeat (6) @(negedge CLK);
    set_op(1, y);
    wait_done(0, 60, n);
    checks++;
    if (done_m !== 4'b0010 || dout_m !== isqrt(x) || n !== 29) begin
      errors++;
      $display("FAIL data_latched: done=%b dout=%0d cycles=%0d, want 0010/%0d/29", done_m,
               dout_m, n, isqrt(x));
    end
    last_m = 1;
    req_m = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_random_ops();
    longint unsigned specials [6] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                                      64'hFFFF_FFFE_0000_0001, 64'd3, 64'hFFFF_FFFE_0000_0000};
    logic [3:0] held, fresh;
    int n, exp;
    for (int i = 0; i < 4; i++) set_op(i, specials[i]);
    req_m = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      exp = rr_next(req_m, last_m);
      wait_done(0, 60, n);
      checks++;
      if (done_m !== (4'b1 << exp) || grant_m !== done_m || n !== ((k == 0) ? 35 : 36)) begin
        errors++;
        $display("FAIL rand_grant[%0d]: done=%b grant=%b cycles=%0d, want %b", k, done_m,
                 grant_m, n, 4'b1 << exp);
      end
      checks++;
      if (dout_m !== isqrt(ops[exp]) || err_m !== 1'b0) begin
        errors++;
        $display("FAIL rand_data[%0d]: op=%0d dout=%0d err=%b, want %0d/0", k, ops[exp],
                 dout_m, err_m, isqrt(ops[exp]));
      end
      last_m = exp;
      held = req_m & ~(4'b1 << exp);
      fresh = 4'($urandom_range(0, 15)) & ~held;
      if ((held | fresh) == 4'b0) fresh = 4'b1 << $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        if (fresh[i]) set_op(i, (k < 2) ? specials[4 + k] : rand64());
      end
      req_m = held | fresh;
    end
    req_m = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    int n;
    logic quiet;
    set_op(0, 64'd144);
    req_t = 4'b0001;
    wait_done(1, 30, n);
    checks++;
    if (n !== 9 || done_t !== 4'b0001 || err_t !== 1'b1 || dout_t !== 64'd0) begin
      errors++;
      $display("FAIL timeout_resp: cycles=%0d done=%b err=%b dout=%0d, want 9/0001/1/0", n,
               done_t, err_t, dout_t);
    end
    req_t = 4'b0000;
    @(negedge CLK);
    checks++;
    if (err_t !== 1'b0 || done_t !== 4'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err=%b done=%b, want 0/0", err_t, done_t);
    end
    quiet = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      if (done_t !== 4'b0 || busy_t !== 1'b0 || err_t !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL late_ready: arbiter reacted to READY outside WAIT");
    end
  endtask

  task automatic test_ready_collision();
    int n;
    set_op(0, 64'd1_000_000);
    req_e = 4'b0001;
    wait_done(2, 60, n);
    checks++;
    if (n !== 35 || done_e !== 4'b0001 || err_e !== 1'b0 || dout_e !== isqrt(ops[0])) begin
      errors++;
      $display("FAIL ready_vs_expiry: cycles=%0d done=%b err=%b dout=%0d, want 35/0001/0/%0d",
               n, done_e, err_e, dout_e, isqrt(ops[0]));
    end
    req_e = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_reset_in_wait();
    int n;
    for (int i = 0; i < 4; i++) set_op(i, rand64());
    req_m = 4'b0110;
    repeat (10) @(negedge CLK);
    checks++;
    if (busy_m !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_busy: busy=%b want 1", busy_m);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({grant_m, done_m, err_m, busy_m} !== 10'b0 || dout_m !== 64'd0) begin
      errors++;
      $display("FAIL rstwait_outputs: grant=%b done=%b err=%b busy=%b dout=%0d, want 0",
               grant_m, done_m, err_m, busy_m, dout_m);
    end
    repeat (2) @(negedge CLK);
    req_m = 4'b0111;
    RST = 1'b0;
    last_m = 3;
    wait_done(0, 60, n);
    checks++;
    if (done_m !== (4'b1 << rr_next(req_m, last_m)) || done_m !== 4'b0001 || n !== 35 ||
        dout_m !== isqrt(ops[0])) begin
      errors++;
      $display("FAIL rstwait_first: done=%b cycles=%0d dout=%0d, want 0001/35/%0d", done_m, n,
               dout_m, isqrt(ops[0]));
    end
    req_m = 4'b0000;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_data_change();
    test_random_ops();
    test_timeout();
    test_ready_collision();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "time limit");
  end

endmodule
